// File: rtl/segment_select_sequencer.sv
// Walks the per-variable bound table through the segment selector and streams each
// captured segment downstream. Define SEGSEQ_SWEEP_CNT_EN to add the out_sweep_cnt counter.
module segment_select_sequencer #(
  parameter int NUM_VARS    = 8,
  parameter int IDX_W       = 3,
  parameter int DATA_W      = 8,
  parameter int SEL_LATENCY = 2
) (
  input  logic                     in_clock,
  input  logic                     in_reset,
  input  logic                     in_start,
  input  logic                     in_abort,
  input  logic                     in_cfg_we,
  input  logic [IDX_W-1:0]         in_cfg_addr,
  input  logic signed [DATA_W-1:0] in_cfg_less,
  input  logic signed [DATA_W-1:0] in_cfg_more,
  input  logic [1:0]               in_cfg_flag,
  output logic                     out_cfg_err,
  output logic                     out_sel_enable,
  output logic signed [DATA_W-1:0] out_sel_less,
  output logic signed [DATA_W-1:0] out_sel_more,
  output logic [1:0]               out_sel_flag,
  input  logic [1:0]               in_seg_type,
  input  logic signed [DATA_W-1:0] in_seg_from,
  input  logic signed [DATA_W-1:0] in_seg_to,
  input  logic signed [DATA_W-1:0] in_seg_weight,
  output logic                     out_seg_valid,
  input  logic                     in_seg_ready,
  output logic [IDX_W-1:0]         out_seg_index,
  output logic [1:0]               out_seg_type,
  output logic signed [DATA_W-1:0] out_seg_from,
  output logic signed [DATA_W-1:0] out_seg_to,
  output logic signed [DATA_W-1:0] out_seg_weight,
  output logic                     out_busy,
  output logic                     out_done
`ifdef SEGSEQ_SWEEP_CNT_EN
  ,
  output logic [15:0]              out_sweep_cnt
`endif
);

  localparam int CNT_W = (SEL_LATENCY > 1) ? $clog2(SEL_LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SEL_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NUM_VARS-1:0][DATA_W-1:0] tbl_less_q, tbl_less_d;
  logic [NUM_VARS-1:0][DATA_W-1:0] tbl_more_q, tbl_more_d;
  logic [NUM_VARS-1:0][1:0]        tbl_flag_q, tbl_flag_d;
  logic                            valid_q, valid_d;
  logic [1:0]                      seg_type_q, seg_type_d;
  logic [DATA_W-1:0]               seg_from_q, seg_from_d;
  logic [DATA_W-1:0]               seg_to_q, seg_to_d;
  logic [DATA_W-1:0]               seg_weight_q, seg_weight_d;
  logic                            cfg_err_q, cfg_err_d;

  logic addr_ok;
  logic cfg_commit;
  logic at_last;

  // Widened compare so NUM_VARS == 2**IDX_W still fits the constant.
  assign addr_ok    = ({1'b0, in_cfg_addr} < (IDX_W + 1)'(NUM_VARS));
  assign cfg_commit = in_cfg_we && (state_q == ST_IDLE) && addr_ok;
  assign at_last    = (idx_q == LAST_IDX);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    seg_type_d   = seg_type_q;
    seg_from_d   = seg_from_q;
    seg_to_d     = seg_to_q;
    seg_weight_d = seg_weight_q;
    tbl_less_d   = tbl_less_q;
    tbl_more_d   = tbl_more_q;
    tbl_flag_d   = tbl_flag_q;
    cfg_err_d    = in_cfg_we && !cfg_commit;

    if (cfg_commit) begin
      tbl_less_d[in_cfg_addr] = in_cfg_less;
      tbl_more_d[in_cfg_addr] = in_cfg_more;
      tbl_flag_d[in_cfg_addr] = in_cfg_flag;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (tbl_flag_q[idx_q] == 2'd0) begin
          if (at_last) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          seg_type_d   = in_seg_type;
          seg_from_d   = in_seg_from;
          seg_to_d     = in_seg_to;
          seg_weight_d = in_seg_weight;
          valid_d      = 1'b1;
          state_d      = ST_OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (valid_q && in_seg_ready) begin
          valid_d = 1'b0;
          if (at_last) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    // Abort overrides every transition above, including a start seen in IDLE.
    if (in_abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      seg_type_q   <= '0;
      seg_from_q   <= '0;
      seg_to_q     <= '0;
      seg_weight_q <= '0;
      cfg_err_q    <= 1'b0;
      // NOTE: the bound table is reset on purpose: a sweep after reset must see every entry as skip.
      tbl_less_q   <= '0;
      tbl_more_q   <= '0;
      tbl_flag_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      seg_type_q   <= seg_type_d;
      seg_from_q   <= seg_from_d;
      seg_to_q     <= seg_to_d;
      seg_weight_q <= seg_weight_d;
      cfg_err_q    <= cfg_err_d;
      tbl_less_q   <= tbl_less_d;
      tbl_more_q   <= tbl_more_d;
      tbl_flag_q   <= tbl_flag_d;
    end
  end

  assign out_cfg_err    = cfg_err_q;
  assign out_sel_enable = (state_q == ST_ISSUE);
  assign out_sel_less   = tbl_less_q[idx_q];
  assign out_sel_more   = tbl_more_q[idx_q];
  assign out_sel_flag   = tbl_flag_q[idx_q];
  assign out_seg_valid  = valid_q;
  assign out_seg_index  = idx_q;
  assign out_seg_type   = seg_type_q;
  assign out_seg_from   = seg_from_q;
  assign out_seg_to     = seg_to_q;
  assign out_seg_weight = seg_weight_q;
  assign out_busy       = (state_q != ST_IDLE);
  assign out_done       = (state_q == ST_DONE);

`ifdef SEGSEQ_SWEEP_CNT_EN
  logic [15:0] sweep_cnt_q, sweep_cnt_d;

  // Abort never reaches DONE, so only completed sweeps are counted.
  always_comb begin
    sweep_cnt_d = sweep_cnt_q + {15'd0, (state_q == ST_DONE)};
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      sweep_cnt_q <= '0;
    end else begin
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  assign out_sweep_cnt = sweep_cnt_q;
`endif

  a_valid_hold: assert property (@(posedge in_clock) disable iff (in_reset)
    (valid_q && !in_seg_ready && !in_abort) |=> valid_q);

  a_payload_hold: assert property (@(posedge in_clock) disable iff (in_reset)
    (valid_q && !in_seg_ready && !in_abort)
      |=> $stable({idx_q, seg_type_q, seg_from_q, seg_to_q, seg_weight_q}));

  a_idx_range: assert property (@(posedge in_clock) disable iff (in_reset)
    idx_q <= LAST_IDX);

endmodule

// File: tb/tb_segment_select_sequencer.sv
// Randomised bench for segment_select_sequencer: a selector stub feeds results and a
// table/timing model derived from the sweep rules predicts segments and completion cycles.
module tb_segment_select_sequencer;

  localparam int NV      = 8;
  localparam int SEL_LAT = 2;

  logic              in_clock;
  logic              in_reset;
  logic              in_start;
  logic              in_abort;
  logic              in_cfg_we;
  logic [2:0]        in_cfg_addr;
  logic signed [7:0] in_cfg_less;
  logic signed [7:0] in_cfg_more;
  logic [1:0]        in_cfg_flag;
  logic [1:0]        in_seg_type;
  logic signed [7:0] in_seg_from;
  logic signed [7:0] in_seg_to;
  logic signed [7:0] in_seg_weight;
  logic              in_seg_ready;

  logic              out_cfg_err, out_sel_enable, out_seg_valid, out_busy, out_done;
  logic signed [7:0] out_sel_less, out_sel_more;
  logic [1:0]        out_sel_flag, out_seg_type;
  logic [2:0]        out_seg_index;
  logic signed [7:0] out_seg_from, out_seg_to, out_seg_weight;

  logic              s_cfg_err, s_sel_enable, s_seg_valid, s_busy, s_done;
  logic signed [7:0] s_sel_less, s_sel_more, s_seg_from, s_seg_to, s_seg_weight;
  logic [1:0]        s_sel_flag, s_seg_type;
  logic [2:0]        s_seg_index;

`ifdef SEGSEQ_SWEEP_CNT_EN
  logic [15:0]       out_sweep_cnt, s_sweep_cnt;
`endif

  segment_select_sequencer #(.NUM_VARS(NV), .IDX_W(3), .DATA_W(8), .SEL_LATENCY(SEL_LAT)) dut (
    .in_clock(in_clock), .in_reset(in_reset), .in_start(in_start), .in_abort(in_abort),
    .in_cfg_we(in_cfg_we), .in_cfg_addr(in_cfg_addr), .in_cfg_less(in_cfg_less),
    .in_cfg_more(in_cfg_more), .in_cfg_flag(in_cfg_flag), .out_cfg_err(out_cfg_err),
    .out_sel_enable(out_sel_enable), .out_sel_less(out_sel_less), .out_sel_more(out_sel_more),
    .out_sel_flag(out_sel_flag), .in_seg_type(in_seg_type), .in_seg_from(in_seg_from),
    .in_seg_to(in_seg_to), .in_seg_weight(in_seg_weight), .out_seg_valid(out_seg_valid),
    .in_seg_ready(in_seg_ready), .out_seg_index(out_seg_index), .out_seg_type(out_seg_type),
    .out_seg_from(out_seg_from), .out_seg_to(out_seg_to), .out_seg_weight(out_seg_weight),
    .out_busy(out_busy), .out_done(out_done)
`ifdef SEGSEQ_SWEEP_CNT_EN
    , .out_sweep_cnt(out_sweep_cnt)
`endif
  );

  // Five-entry instance sharing the config bus, so addresses 5..7 are out of range for it.
  segment_select_sequencer #(.NUM_VARS(5), .IDX_W(3), .DATA_W(8), .SEL_LATENCY(SEL_LAT)) dut_small (
    .in_clock(in_clock), .in_reset(in_reset), .in_start(in_start), .in_abort(in_abort),
    .in_cfg_we(in_cfg_we), .in_cfg_addr(in_cfg_addr), .in_cfg_less(in_cfg_less),
    .in_cfg_more(in_cfg_more), .in_cfg_flag(in_cfg_flag), .out_cfg_err(s_cfg_err),
    .out_sel_enable(s_sel_enable), .out_sel_less(s_sel_less), .out_sel_more(s_sel_more),
    .out_sel_flag(s_sel_flag), .in_seg_type(in_seg_type), .in_seg_from(in_seg_from),
    .in_seg_to(in_seg_to), .in_seg_weight(in_seg_weight), .out_seg_valid(s_seg_valid),
    .in_seg_ready(in_seg_ready), .out_seg_index(s_seg_index), .out_seg_type(s_seg_type),
    .out_seg_from(s_seg_from), .out_seg_to(s_seg_to), .out_seg_weight(s_seg_weight),
    .out_busy(s_busy), .out_done(s_done)
`ifdef SEGSEQ_SWEEP_CNT_EN
    , .out_sweep_cnt(s_sweep_cnt)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int sweeps_done = 0;

  logic [7:0] m_less [NV];
  logic [7:0] m_more [NV];
  logic [1:0] m_flag [NV];
  logic [7:0] stub_w [$];

  initial in_clock = 1'b0;
  always #5 in_clock = ~in_clock;
  always @(posedge in_clock) cyc <= cyc + 1;

  // Selector stub: correct result only in the cycle SEL_LAT after each enable, noise otherwise.
  initial begin : selector_stub
    int         pend;
    logic [1:0] lat_flag;
    logic [7:0] lat_less, lat_more, w;
    pend = -1;
    lat_flag = '0; lat_less = '0; lat_more = '0;
    in_seg_type = '0; in_seg_from = '0; in_seg_to = '0; in_seg_weight = '0;
    forever begin
      @(negedge in_clock);
      if (pend == 0) begin
        w = 8'($urandom);
        in_seg_type = lat_flag; in_seg_from = lat_less; in_seg_to = lat_more; in_seg_weight = w;
        stub_w.push_back(w);
      end else begin
        in_seg_type = 2'($urandom); in_seg_from = 8'($urandom);
        in_seg_to = 8'($urandom); in_seg_weight = 8'($urandom);
      end
      if (pend >= 0) pend--;
      if (out_sel_enable) begin
        pend = SEL_LAT - 1;
        lat_flag = out_sel_flag; lat_less = out_sel_less; lat_more = out_sel_more;
      end
    end
  end

  function automatic logic [51:0] all_outs();
    return {out_busy, out_done, out_sel_enable, out_seg_valid, out_cfg_err, out_sel_less,
            out_sel_more, out_sel_flag, out_seg_index, out_seg_type, out_seg_from, out_seg_to,
            out_seg_weight};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NV; i++) begin
      m_less[i] = '0; m_more[i] = '0; m_flag[i] = '0;
    end
    sweeps_done = 0;
  endtask

  task automatic check_sweep_cnt(input string tag);
`ifdef SEGSEQ_SWEEP_CNT_EN
    vectors++;
    if (out_sweep_cnt !== 16'(sweeps_done)) begin
      miscompares++;
      $display("FAIL %s sweep_cnt: got %0d expected %0d", tag, out_sweep_cnt, sweeps_done);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic cfg_write(input int addr, input logic [7:0] less, input logic [7:0] more,
                           input logic [1:0] flag, input bit exp_err, input int exp_small);
    @(negedge in_clock);
    in_cfg_we = 1'b1; in_cfg_addr = 3'(addr);
    in_cfg_less = less; in_cfg_more = more; in_cfg_flag = flag;
    @(negedge in_clock);
    in_cfg_we = 1'b0;
    vectors++;
    if (out_cfg_err !== exp_err) begin
      miscompares++;
      $display("FAIL cfg_err addr %0d: got %b expected %b", addr, out_cfg_err, exp_err);
    end
    if (exp_small >= 0) begin
      vectors++;
      if (s_cfg_err !== 1'(exp_small)) begin
        miscompares++;
        $display("FAIL cfg_err_small addr %0d: got %b expected %0d", addr, s_cfg_err, exp_small);
      end
    end
    if (!exp_err) begin
      m_less[addr] = less; m_more[addr] = more; m_flag[addr] = flag;
    end
  endtask

  // ready_mode: 0 always ready, 1 random, 2 hold off 5 valid cycles per segment.
  task automatic run_sweep(input int ready_mode, input bit poke_err, input bit start_wr);
    int         exp_idx [$];
    int         total, stalls, enables, nseg, nexp, start_edge, stall_run, poke_at, h_idx;
    bit         err_exp, pending, finished;
    logic [1:0] h_type;
    logic [7:0] h_from, h_to, h_w;
    total = 0; stalls = 0; enables = 0; nseg = 0; stall_run = 0;
    err_exp = 0; pending = 0; finished = 0;
    h_idx = 0; h_type = '0; h_from = '0; h_to = '0; h_w = '0;
    for (int i = 0; i < NV; i++) begin
      if (m_flag[i] == 2'd0) total += 1;
      else begin
        total += SEL_LAT + 3;
        exp_idx.push_back(i);
      end
    end
    nexp = exp_idx.size();
    poke_at = $urandom_range(0, total - 1);
    stub_w.delete();
    @(negedge in_clock);
    in_start = 1'b1;
    if (start_wr) begin
      in_cfg_we = 1'b1; in_cfg_addr = 3'd0;
      in_cfg_less = m_less[0]; in_cfg_more = m_more[0]; in_cfg_flag = m_flag[0];
    end
    start_edge = cyc + 1;
    for (int c = 0; c < 4000 && !finished; c++) begin
      @(negedge in_clock);
      in_start = 1'b0; in_cfg_we = 1'b0;
      vectors++;
      if (out_cfg_err !== err_exp) begin
        miscompares++;
        $display("FAIL sweep cfg_err cyc %0d: got %b expected %b", cyc, out_cfg_err, err_exp);
      end
      err_exp = 0;
      if (out_sel_enable) enables++;
      if (out_seg_valid) begin
        if (!pending) begin
          stall_run = 0;
          if (exp_idx.size() == 0 || stub_w.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL extra_segment: got index %0d, none expected", out_seg_index);
          end else begin
            h_idx = exp_idx.pop_front();
            h_type = m_flag[h_idx]; h_from = m_less[h_idx]; h_to = m_more[h_idx];
            h_w = stub_w.pop_front();
          end
        end
        vectors++;
        if ({out_seg_index, out_seg_type, out_seg_from, out_seg_to, out_seg_weight} !==
            {3'(h_idx), h_type, h_from, h_to, h_w}) begin
          miscompares++;
          $display("FAIL segment%s: got idx %0d type %0d from %0d to %0d w %0d expected idx %0d type %0d from %0d to %0d w %0d",
                   pending ? "_hold" : "", out_seg_index, out_seg_type, out_seg_from, out_seg_to,
                   out_seg_weight, h_idx, h_type, $signed(h_from), $signed(h_to), $signed(h_w));
        end
        case (ready_mode)
          0:       in_seg_ready = 1'b1;
          1:       in_seg_ready = 1'($urandom_range(0, 1));
          default: in_seg_ready = (stall_run >= 5);
        endcase
        if (in_seg_ready) begin
          nseg++; pending = 0;
        end else begin
          stalls++; stall_run++; pending = 1;
        end
      end else begin
        if (pending) begin
          vectors++; miscompares++; pending = 0;
          $display("FAIL valid_dropped: got valid 0 expected 1 at cyc %0d", cyc);
        end
        in_seg_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (out_done) begin
        finished = 1;
        vectors++;
        if (cyc !== start_edge + total + stalls) begin
          miscompares++;
          $display("FAIL done_cycle: got %0d expected %0d", cyc - start_edge, total + stalls);
        end
        vectors++;
        if (nseg !== nexp || enables !== nexp) begin
          miscompares++;
          $display("FAIL seg_count: got %0d segs %0d enables expected %0d", nseg, enables, nexp);
        end
      end else begin
        vectors++;
        if (out_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy: got %b expected 1 at cyc %0d", out_busy, cyc);
        end
        if (poke_err && c == poke_at) begin
          in_cfg_we = 1'b1; in_cfg_addr = 3'($urandom_range(0, NV - 1));
          in_cfg_less = 8'($urandom); in_cfg_more = 8'($urandom); in_cfg_flag = 2'($urandom);
          err_exp = 1;
        end
      end
    end
    if (!finished) begin
      vectors++; miscompares++;
      $display("FAIL sweep_timeout: got no done expected done after %0d cycles", total + stalls);
    end
    sweeps_done++;
    @(negedge in_clock);
    vectors++;
    if ({out_busy, out_done, out_seg_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL post_sweep: got busy/done/valid %b expected 000", {out_busy, out_done, out_seg_valid});
    end
    check_sweep_cnt("post_sweep");
  endtask

  task automatic test_reset();
    in_reset = 1'b1;
    repeat (3) @(negedge in_clock);
    in_reset = 1'b0;
    clear_model();
    for (int i = 0; i < 10; i++) begin
      @(negedge in_clock);
      vectors++;
      if (all_outs() !== '0) begin
        miscompares++;
        $display("FAIL reset_idle: got %h expected 0", all_outs());
      end
    end
    check_sweep_cnt("reset");
  endtask

  task automatic test_cfg_range();
    for (int a = 0; a < NV; a++)
      cfg_write(a, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, (a >= 5) ? 1 : 0);
    run_sweep(1, 1'b0, 1'b0);
  endtask

  task automatic test_full_sweep();
    for (int i = 0; i < NV; i++) cfg_write(i, 8'd10, 8'(-5), 2'd3, 1'b0, -1);
    run_sweep(0, 1'b0, 1'b0);
  endtask

  task automatic test_single_entry();
    for (int i = 0; i < NV; i++)
      cfg_write(i, (i == 2) ? 8'd20 : 8'd0, 8'd0, (i == 2) ? 2'd1 : 2'd0, 1'b0, -1);
    run_sweep(0, 1'b0, 1'b0);
  endtask

  task automatic random_table(input bit all_active);
    for (int i = 0; i < NV; i++)
      cfg_write(i, 8'($urandom), 8'($urandom),
                all_active ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3)), 1'b0, -1);
  endtask

  task automatic test_backpressure();
    random_table(1'b0);
    cfg_write(1, 8'($urandom), 8'($urandom), 2'd2, 1'b0, -1);
    run_sweep(2, 1'b0, 1'b0);
  endtask

  task automatic test_cfg_during_sweep();
    for (int r = 0; r < 2; r++) begin
      random_table(1'b0);
      run_sweep(1, 1'b1, 1'b0);
      run_sweep(0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_start_with_write();
    m_less[0] = 8'($urandom); m_more[0] = 8'($urandom); m_flag[0] = 2'($urandom_range(1, 3));
    run_sweep(0, 1'b0, 1'b1);
    m_flag[0] = 2'd0;
    run_sweep(1, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    int n;
    bit hit;
    random_table(1'b1);
    @(negedge in_clock);
    in_start = 1'b1; in_seg_ready = 1'b1;
    n = 0; hit = 0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge in_clock);
      in_start = 1'b0;
      if (out_sel_enable) begin
        n++;
        if (n == 5) hit = 1;
      end
    end
    @(negedge in_clock);
    vectors++;
    if (!hit || out_seg_index !== 3'd4 || out_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_reach: got hit %b index %0d busy %b expected 1 4 1", hit, out_seg_index, out_busy);
    end
    in_abort = 1'b1;
    @(negedge in_clock);
    in_abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if ({out_busy, out_done, out_seg_valid, out_sel_enable} !== 4'b0000) begin
        miscompares++;
        $display("FAIL abort_idle: got busy/done/valid/en %b expected 0000",
                 {out_busy, out_done, out_seg_valid, out_sel_enable});
      end
      @(negedge in_clock);
    end
    in_start = 1'b1; in_abort = 1'b1;
    @(negedge in_clock);
    in_start = 1'b0; in_abort = 1'b0;
    vectors++;
    if (out_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_beats_start: got busy %b expected 0", out_busy);
    end
    check_sweep_cnt("abort");
    run_sweep(0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      random_table(1'b0);
      run_sweep(1, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_reset_mid_sweep();
    random_table(1'b1);
    @(negedge in_clock);
    in_start = 1'b1;
    repeat ($urandom_range(3, 15)) begin
      @(negedge in_clock);
      in_start = 1'b0;
      in_seg_ready = 1'($urandom_range(0, 1));
    end
    in_reset = 1'b1; in_start = 1'b1;
    in_cfg_we = 1'b1; in_cfg_addr = 3'($urandom_range(0, NV - 1));
    in_cfg_less = 8'($urandom); in_cfg_more = 8'($urandom); in_cfg_flag = 2'd3;
    @(negedge in_clock);
    in_reset = 1'b0; in_start = 1'b0; in_cfg_we = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (all_outs() !== '0) begin
        miscompares++;
        $display("FAIL reset_mid: got %h expected 0", all_outs());
      end
      @(negedge in_clock);
    end
    check_sweep_cnt("reset_mid");
    run_sweep(1, 1'b0, 1'b0);
  endtask

  initial begin
    in_reset = 1'b1; in_start = 1'b0; in_abort = 1'b0; in_cfg_we = 1'b0;
    in_cfg_addr = '0; in_cfg_less = '0; in_cfg_more = '0; in_cfg_flag = '0;
    in_seg_ready = 1'b0;
    test_reset();
    test_cfg_range();
    test_full_sweep();
    test_single_entry();
    test_backpressure();
    test_cfg_during_sweep();
    test_start_with_write();
    test_abort();
    test_random();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
